// File: rtl/n_bit_cla_adder_pipeline_optimized.sv
// Purpose: pipelined unsigned two-level carry-look-ahead adder, {carry_out,sum} = in1 + in2 + carry_in.
// Latency: 2 cycles (input register, then compute + output register); one operation accepted per clock.
// Backpressure: none; inputs are sampled every cycle and results stream out in order.
module n_bit_cla_adder_pipeline_optimized #(
  parameter int DATA_WID = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [DATA_WID-1:0] in1,
  input  logic [DATA_WID-1:0] in2,
  input  logic                carry_in,
  output logic [DATA_WID-1:0] sum,
  output logic                carry_out
);

  localparam int NB = DATA_WID / 4;

  // Second-level look-ahead: every block carry is a flat sum of products of
  // block generate/propagate terms and the adder carry-in, so no block waits
  // on the carry of its neighbour.
  function automatic logic [NB:0] f_lookahead(input logic [NB-1:0] gg,
                                             input logic [NB-1:0] pp,
                                             input logic          cin);
    logic [NB:0] c;
    logic        prod;
    c    = '0;
    c[0] = cin;
    for (int j = 1; j <= NB; j++) begin
      prod = cin;
      for (int m = 0; m < j; m++) prod = prod & pp[m];
      c[j] = prod;
      for (int k = 0; k < j; k++) begin
        prod = gg[k];
        for (int m = k + 1; m < j; m++) prod = prod & pp[m];
        c[j] = c[j] | prod;
      end
    end
    return c;
  endfunction

  logic [DATA_WID-1:0] r_in1;
  logic [DATA_WID-1:0] r_in2;
  logic                r_cin;
  logic [DATA_WID-1:0] r_sum;
  logic                r_cout;

  logic [DATA_WID-1:0] w_g;
  logic [DATA_WID-1:0] w_p;
  logic [DATA_WID-1:0] w_c;
  logic [NB-1:0]       w_blk_g;
  logic [NB-1:0]       w_blk_p;
  logic [NB:0]         w_blk_c;

  assign w_g = r_in1 & r_in2;
  assign w_p = r_in1 ^ r_in2;

  // Block carries from the flattened look-ahead unit.
  always_comb begin
    w_blk_c = f_lookahead(w_blk_g, w_blk_p, r_cin);
  end

  genvar b;
  generate
    for (b = 0; b < NB; b++) begin : g_blk
      logic [3:0] w_bg;
      logic [3:0] w_bp;
      logic       w_bc;
      assign w_bg = w_g[4*b +: 4];
      assign w_bp = w_p[4*b +: 4];
      assign w_bc = w_blk_c[b];

      // Group generate / propagate of this 4-bit block.
      assign w_blk_g[b] = w_bg[3]
                        | (w_bp[3] & w_bg[2])
                        | (w_bp[3] & w_bp[2] & w_bg[1])
                        | (w_bp[3] & w_bp[2] & w_bp[1] & w_bg[0]);
      assign w_blk_p[b] = &w_bp;

      // In-block look-ahead carries, each directly from the block carry-in.
      assign w_c[4*b]   = w_bc;
      assign w_c[4*b+1] = w_bg[0] | (w_bp[0] & w_bc);
      assign w_c[4*b+2] = w_bg[1] | (w_bp[1] & w_bg[0]) | (w_bp[1] & w_bp[0] & w_bc);
      assign w_c[4*b+3] = w_bg[2] | (w_bp[2] & w_bg[1]) | (w_bp[2] & w_bp[1] & w_bg[0])
                        | (w_bp[2] & w_bp[1] & w_bp[0] & w_bc);
    end
  endgenerate

  // Stage 1: capture operands every cycle; reset drops whatever is presented.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_in1 <= '0;
      r_in2 <= '0;
      r_cin <= 1'b0;
    end else begin
      r_in1 <= in1;
      r_in2 <= in2;
      r_cin <= carry_in;
    end
  end

  // Stage 2: register the look-ahead result; reset discards the in-flight op.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else begin
      r_sum  <= w_p ^ w_c;
      r_cout <= w_blk_c[NB];
    end
  end

  assign sum       = r_sum;
  assign carry_out = r_cout;

endmodule

// File: tb/tb_n_bit_cla_adder_pipeline_optimized.sv
// Bench for the pipelined CLA adder: arithmetic reference with a 2-edge delay line,
// checked every cycle, plus hand-computed literal expectations on directed vectors.
module tb_n_bit_cla_adder_pipeline_optimized;

  localparam int W = 32;

  logic         clock;
  logic         reset;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic         carry_in;
  logic [W-1:0] sum;
  logic         carry_out;

  int n_cmp = 0;
  int n_bad = 0;

  n_bit_cla_adder_pipeline_optimized #(.DATA_WID(W)) dut (
    .clock    (clock),
    .reset    (reset),
    .in1      (in1),
    .in2      (in2),
    .carry_in (carry_in),
    .sum      (sum),
    .carry_out(carry_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: the result of each captured operand set is their plain 33-bit
  // sum; it reaches the output one edge after capture. Reset zeroes both.
  logic [W:0] m_cap;
  logic [W:0] m_out;
  bit         chk_en = 1'b0;

  always @(posedge clock) begin
    if (reset) begin
      m_out <= '0;
      m_cap <= '0;
      chk_en <= 1'b1;
    end else begin
      m_out <= m_cap;
      m_cap <= {1'b0, in1} + {1'b0, in2} + {{W{1'b0}}, carry_in};
    end
  end

  // Every-cycle comparison against the reference, away from the active edge.
  always @(negedge clock) begin
    if (chk_en) begin
      n_cmp++;
      if ({carry_out, sum} !== m_out) begin
        n_bad++;
        $display("FAIL model t=%0t got carry=%0b sum=%h want carry=%0b sum=%h",
                 $time, carry_out, sum, m_out[W], m_out[W-1:0]);
      end
    end
  end

  // Drive one operand set and advance to the next falling edge.
  task automatic cyc(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    in1      = a;
    in2      = b;
    carry_in = c;
    @(negedge clock);
  endtask

  // Hand-computed expectation; pins both the DUT and the reference.
  task automatic lit(input string name, input logic [W:0] exp);
    n_cmp++;
    if ({carry_out, sum} !== exp) begin
      n_bad++;
      $display("FAIL %s dut carry=%0b sum=%h want carry=%0b sum=%h",
               name, carry_out, sum, exp[W], exp[W-1:0]);
    end
    n_cmp++;
    if (m_out !== exp) begin
      n_bad++;
      $display("FAIL %s_ref ref=%h want=%h", name, m_out, exp);
    end
  endtask

  initial begin
    reset    = 1'b1;
    in1      = '0;
    in2      = '0;
    carry_in = 1'b0;
    @(negedge clock);

    // Reset held for 10 cycles, with nonzero operands that must be dropped.
    for (int i = 0; i < 10; i++) begin
      lit("reset_hold", 33'h0);
      cyc(32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
    end
    reset = 1'b0;
    cyc('0, '0, 1'b0);
    lit("post_reset0", 33'h0);
    cyc('0, '0, 1'b0);
    lit("post_reset1", 33'h0);

    // 5 + 10, then zeros.
    cyc(32'd5, 32'd10, 1'b0);
    cyc('0, '0, 1'b0);
    lit("five_plus_ten", 33'h0_0000_000F);
    cyc('0, '0, 1'b0);
    lit("after_15", 33'h0);

    // Carry-in used, mixed nibbles.
    cyc(32'h0000_ABCD, 32'h0000_1234, 1'b1);
    cyc('0, '0, 1'b0);
    lit("abcd_1234_c1", 33'h0_0000_BE02);

    // All-ones cases exercising the full carry chain.
    cyc(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    cyc(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    lit("ones_plus_ones", 33'h1_FFFF_FFFE);
    cyc('0, '0, 1'b0);
    lit("ones_plus_cin", 33'h1_0000_0000);
    cyc(32'h0000_FFFF, 32'h0000_0001, 1'b0);
    cyc('0, '0, 1'b0);
    lit("carry_into_blk4", 33'h0_0001_0000);

    // Back-to-back operations, no bubbles.
    cyc(32'd1, 32'd1, 1'b0);
    cyc(32'd2, 32'd2, 1'b0);
    lit("b2b_1", 33'h0_0000_0002);
    cyc(32'h8000_0000, 32'h8000_0000, 1'b0);
    lit("b2b_2", 33'h0_0000_0004);
    cyc('0, '0, 1'b0);
    lit("b2b_3", 33'h1_0000_0000);
    cyc('0, '0, 1'b0);
    lit("b2b_drain", 33'h0);

    // Reset while operations are in flight.
    cyc(32'd100, 32'd200, 1'b0);
    reset = 1'b1;
    cyc(32'd7, 32'd9, 1'b1);
    lit("reset_flush", 33'h0);
    reset = 1'b0;
    cyc(32'h1234_0000, 32'h0000_4321, 1'b1);
    lit("reset_first0", 33'h0);
    cyc('0, '0, 1'b0);
    lit("after_reset_op", 33'h0_1234_4322);

    // Pseudo-random streaming checked by the reference only.
    for (int i = 0; i < 200; i++) cyc($urandom, $urandom, 1'($urandom_range(0, 1)));
    cyc('0, '0, 1'b0);
    cyc('0, '0, 1'b0);
    lit("final_idle", 33'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
